// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared lamp and phase encodings for the N-road traffic controller
package traffic_pkg;

    // Width of one road's lamp field in the lights bus
    localparam int LIGHT_W = 2;

    // Lamp colour driven per road
    typedef enum logic [LIGHT_W-1:0] {
        LT_RED    = 2'd0,
        LT_YELLOW = 2'd1,
        LT_GREEN  = 2'd2
    } light_t;

    // Phase owned by the active road
    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_t;

endpackage

// File: rtl/traffic_arbiter_n.sv
// rtl/traffic_arbiter_n.sv - picks the most crowded unserved road, lowest index on ties
module traffic_arbiter_n
    import traffic_pkg::*;
#(
    parameter int N_ROADS = 4,
    parameter int SENS_W  = 3
) (
    input  logic [N_ROADS*SENS_W-1:0]  sens,
    input  logic [N_ROADS-1:0]         served,
    input  logic                       all_served,
    output logic [$clog2(N_ROADS)-1:0] next_road,
    output logic [N_ROADS-1:0]         next_served
);

    localparam int RW = $clog2(N_ROADS);

    logic [RW-1:0]     best_idx;
    logic [SENS_W-1:0] best_val;
    logic              found;

    // Linear scan with strict greater-than so the first (lowest) index wins a tie;
    // a full round restarts at road 0 regardless of occupancy
    always_comb begin
        best_idx = '0;
        best_val = '0;
        found    = 1'b0;
        for (int i = 0; i < N_ROADS; i++) begin
            if (!served[i] && (!found || (sens[i*SENS_W +: SENS_W] > best_val))) begin
                found    = 1'b1;
                best_idx = RW'(i);
                best_val = sens[i*SENS_W +: SENS_W];
            end
        end
        if (all_served) begin
            next_road   = '0;
            next_served = N_ROADS'(1);
        end else begin
            next_road   = best_idx;
            next_served = served | (N_ROADS'(1) << best_idx);
        end
    end

endmodule

// File: rtl/traffic_ctrl_n.sv
// rtl/traffic_ctrl_n.sv - N-road single-junction light controller with green extension and all-red clearance
module traffic_ctrl_n
    import traffic_pkg::*;
#(
    parameter int N_ROADS = 4,
    parameter int SENS_W  = 3,
    parameter int G_MIN   = 2,
    parameter int G_MAX   = 8,
    parameter int Y_TIME  = 3,
    parameter int AR_TIME = 1,
    parameter int CNT_W   = 4
) (
    input  logic                       clock,
    input  logic                       clear,
    input  logic [N_ROADS*SENS_W-1:0]  sens,
    output logic [2*N_ROADS-1:0]       lights,
    output logic [N_ROADS-1:0]         served,
    output logic [$clog2(N_ROADS)-1:0] active_road,
    output logic [1:0]                 phase
);

    localparam int RW = $clog2(N_ROADS);
    localparam int LW = LIGHT_W * N_ROADS;

    localparam logic [CNT_W-1:0] G_MIN_LAST = CNT_W'(G_MIN - 1);
    localparam logic [CNT_W-1:0] G_MAX_LAST = CNT_W'(G_MAX - 1);
    localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(Y_TIME - 1);
    localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'((AR_TIME > 0) ? (AR_TIME - 1) : 0);
    localparam logic [CNT_W-1:0] TIMER_SAT  = '1;
    localparam logic [LW-1:0]    LIGHTS_RST = LW'(LT_GREEN);

    phase_t            phase_q,  phase_d;
    logic [CNT_W-1:0]  timer_q,  timer_d;
    logic [RW-1:0]     active_q, active_d;
    logic [N_ROADS-1:0] served_q, served_d;
    logic [LW-1:0]     lights_q, lights_d;

    logic [SENS_W-1:0]  act_sens;
    logic               do_select;
    logic [RW-1:0]      arb_road;
    logic [N_ROADS-1:0] arb_served;

    traffic_arbiter_n #(
        .N_ROADS (N_ROADS),
        .SENS_W  (SENS_W)
    ) u_arbiter (
        .sens        (sens),
        .served      (served_q),
        .all_served  (&served_q),
        .next_road   (arb_road),
        .next_served (arb_served)
    );

    assign act_sens = sens[active_q*SENS_W +: SENS_W];

    // Phase sequencing and timer; the arbiter result is only taken on the cycle a new green starts
    always_comb begin
        phase_d   = phase_q;
        timer_d   = (timer_q == TIMER_SAT) ? timer_q : timer_q + 1'b1;
        active_d  = active_q;
        served_d  = served_q;
        do_select = 1'b0;
        case (phase_q)
            PH_GREEN: begin
                if (((timer_q >= G_MIN_LAST) && (act_sens == '0)) || (timer_q == G_MAX_LAST)) begin
                    phase_d = PH_YELLOW;
                    timer_d = '0;
                end
            end
            PH_YELLOW: begin
                if (timer_q == Y_LAST) begin
                    timer_d = '0;
                    if (AR_TIME == 0) begin
                        do_select = 1'b1;
                    end else begin
                        phase_d = PH_ALLRED;
                    end
                end
            end
            PH_ALLRED: begin
                if (timer_q == AR_LAST) begin
                    timer_d   = '0;
                    do_select = 1'b1;
                end
            end
            default: begin
                phase_d = PH_GREEN;
                timer_d = '0;
            end
        endcase
        if (do_select) begin
            phase_d  = PH_GREEN;
            active_d = arb_road;
            served_d = arb_served;
        end
    end

    // Lamps follow the next state so they are registered alongside it; only the active road is ever lit
    always_comb begin
        lights_d = '0;
        for (int i = 0; i < N_ROADS; i++) begin
            if (RW'(i) == active_d) begin
                case (phase_d)
                    PH_GREEN:  lights_d[LIGHT_W*i +: LIGHT_W] = LT_GREEN;
                    PH_YELLOW: lights_d[LIGHT_W*i +: LIGHT_W] = LT_YELLOW;
                    default:   lights_d[LIGHT_W*i +: LIGHT_W] = LT_RED;
                endcase
            end
        end
    end

    // State and output registers; clear wins over any phase in progress
    always_ff @(posedge clock) begin
        if (clear) begin
            phase_q  <= PH_GREEN;
            timer_q  <= '0;
            active_q <= '0;
            served_q <= N_ROADS'(1);
            lights_q <= LIGHTS_RST;
        end else begin
            phase_q  <= phase_d;
            timer_q  <= timer_d;
            active_q <= active_d;
            served_q <= served_d;
            lights_q <= lights_d;
        end
    end

    assign lights      = lights_q;
    assign served      = served_q;
    assign active_road = active_q;
    assign phase       = phase_q;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// tb/tb_traffic_ctrl_n.sv - directed self-checking bench for traffic_ctrl_n
module tb_traffic_ctrl_n;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [11:0] sens  = '0;
    logic [7:0]  lights;
    logic [3:0]  served;
    logic [1:0]  active_road;
    logic [1:0]  phase;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [15:0] obs;
    logic [15:0] exp_v;

    always #5 clock = ~clock;

    traffic_ctrl_n #(
        .N_ROADS (4),
        .SENS_W  (3),
        .G_MIN   (2),
        .G_MAX   (8),
        .Y_TIME  (3),
        .AR_TIME (1),
        .CNT_W   (4)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .sens        (sens),
        .lights      (lights),
        .served      (served),
        .active_road (active_road),
        .phase       (phase)
    );

    function automatic logic [7:0] lamp(input int ph, input int r);
        if (ph == 0) return 8'd2 << (2 * r);
        if (ph == 1) return 8'd1 << (2 * r);
        return 8'd0;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        clear = 1'b1;
        repeat (2) @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        sens = '0;
        do_reset();
        total_cnt++;
        if (lights !== 8'b00_00_00_10) $display("FAIL reset_lights got %b exp %b", lights, 8'b00_00_00_10);
        else pass_cnt++;
        total_cnt++;
        if (served !== 4'b0001) $display("FAIL reset_served got %b exp %b", served, 4'b0001);
        else pass_cnt++;
        total_cnt++;
        if (phase !== 2'd0) $display("FAIL reset_phase got %0d exp %0d", phase, 0);
        else pass_cnt++;
        total_cnt++;
        if (active_road !== 2'd0) $display("FAIL reset_active got %0d exp %0d", active_road, 0);
        else pass_cnt++;
    endtask

    task automatic test_all_zero();
        int          order[5] = '{0, 1, 2, 3, 0};
        logic [3:0]  srv[5]   = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0001};
        int          ph;
        sens = '0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < ((k == 4) ? 2 : 6); c++) begin
                ph    = (c < 2) ? 0 : ((c < 5) ? 1 : 2);
                exp_v = {2'(ph), 2'(order[k]), srv[k], lamp(ph, order[k])};
                obs   = {phase, active_road, served, lights};
                total_cnt++;
                if (obs !== exp_v) $display("FAIL all_zero k=%0d c=%0d got %h exp %h", k, c, obs, exp_v);
                else pass_cnt++;
                @(negedge clock);
            end
        end
    endtask

    task automatic test_priority();
        int          order[5] = '{0, 2, 1, 3, 0};
        int          glen[5]  = '{2, 8, 8, 8, 2};
        logic [3:0]  srv[5]   = '{4'b0001, 4'b0101, 4'b0111, 4'b1111, 4'b0001};
        int          ph;
        sens = {3'd1, 3'd7, 3'd3, 3'd0};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < ((k == 4) ? glen[k] : glen[k] + 4); c++) begin
                ph    = (c < glen[k]) ? 0 : ((c < glen[k] + 3) ? 1 : 2);
                exp_v = {2'(ph), 2'(order[k]), srv[k], lamp(ph, order[k])};
                obs   = {phase, active_road, served, lights};
                total_cnt++;
                if (obs !== exp_v) $display("FAIL priority k=%0d c=%0d got %h exp %h", k, c, obs, exp_v);
                else pass_cnt++;
                @(negedge clock);
            end
        end
    endtask

    task automatic test_extension();
        int ph;
        sens = 12'd7;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            ph    = (c < 8) ? 0 : 1;
            exp_v = {2'(ph), 2'd0, 4'b0001, lamp(ph, 0)};
            obs   = {phase, active_road, served, lights};
            total_cnt++;
            if (obs !== exp_v) $display("FAIL ext_max c=%0d got %h exp %h", c, obs, exp_v);
            else pass_cnt++;
            @(negedge clock);
        end
        sens = 12'd7;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            ph    = (c < 4) ? 0 : 1;
            exp_v = {2'(ph), 2'd0, 4'b0001, lamp(ph, 0)};
            obs   = {phase, active_road, served, lights};
            total_cnt++;
            if (obs !== exp_v) $display("FAIL ext_drop c=%0d got %h exp %h", c, obs, exp_v);
            else pass_cnt++;
            if (c == 3) sens = '0;
            @(negedge clock);
        end
    endtask

    task automatic test_clear_mid();
        int ph;
        sens = '0;
        do_reset();
        repeat (15) @(negedge clock);
        exp_v = {2'd1, 2'd2, 4'b0111, lamp(1, 2)};
        obs   = {phase, active_road, served, lights};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL clear_pre got %h exp %h", obs, exp_v);
        else pass_cnt++;
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        for (int c = 0; c < 3; c++) begin
            ph    = (c < 2) ? 0 : 1;
            exp_v = {2'(ph), 2'd0, 4'b0001, lamp(ph, 0)};
            obs   = {phase, active_road, served, lights};
            total_cnt++;
            if (obs !== exp_v) $display("FAIL clear_post c=%0d got %h exp %h", c, obs, exp_v);
            else pass_cnt++;
            @(negedge clock);
        end
    endtask

    task automatic test_sample_window();
        sens = {3'd0, 3'd0, 3'd7, 3'd0};
        do_reset();
        repeat (5) @(negedge clock);
        exp_v = {2'd2, 2'd0, 4'b0001, 8'd0};
        obs   = {phase, active_road, served, lights};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL window_allred got %h exp %h", obs, exp_v);
        else pass_cnt++;
        sens = {3'd5, 3'd0, 3'd0, 3'd0};
        @(negedge clock);
        exp_v = {2'd0, 2'd3, 4'b1001, lamp(0, 3)};
        obs   = {phase, active_road, served, lights};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL window_final got %h exp %h", obs, exp_v);
        else pass_cnt++;

        sens = {3'd0, 3'd0, 3'd7, 3'd0};
        do_reset();
        repeat (4) @(negedge clock);
        sens = {3'd5, 3'd0, 3'd0, 3'd0};
        @(negedge clock);
        sens = {3'd0, 3'd0, 3'd7, 3'd0};
        @(negedge clock);
        exp_v = {2'd0, 2'd1, 4'b0011, lamp(0, 1)};
        obs   = {phase, active_road, served, lights};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL window_early got %h exp %h", obs, exp_v);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_all_zero();
        test_priority();
        test_extension();
        test_clear_mid();
        test_sample_window();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
